// File: rtl/intraloop_tagpipe.sv
// Macroblock tag pipeline shadowing the intrapred + transformcoder datapath latency.
// Optional build macro INTRALOOP_ORDER_CHECK_EN adds the sticky macroblock sequence check on order_err.
module intraloop_tagpipe #(
  parameter int NUM_CH        = 3,
  parameter int MB_W          = 32,
  parameter int MODE_W        = 3,
  parameter int PRED_LAT      = 3,
  parameter int TC_LAT        = 8,
  parameter int MBS_PER_FRAME = 99
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MB_W-1:0]          in_mbnumber,
  input  logic [NUM_CH*MODE_W-1:0] in_mode,
  output logic                     tc_enable,
  output logic                     recon_valid,
  input  logic                     recon_ready,
  output logic [MB_W-1:0]          recon_mbnumber,
  output logic [NUM_CH*MODE_W-1:0] recon_mode,
  output logic                     pipeline_full,
  output logic                     frame_done,
  output logic                     order_err
);

  localparam int D     = PRED_LAT + TC_LAT;
  localparam int MW    = NUM_CH * MODE_W;
  localparam int OCC_W = $clog2(D + 1);
  localparam int MBC_W = (MBS_PER_FRAME > 1) ? $clog2(MBS_PER_FRAME) : 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(D);
  localparam logic [MBC_W-1:0] MB_LAST  = MBC_W'(MBS_PER_FRAME - 1);

  logic [D-1:0]     vld;
  logic [MB_W-1:0]  mbn [D];
  logic [MW-1:0]    mde [D];
  logic [OCC_W-1:0] occ;
  logic [MBC_W-1:0] mb_cnt;
  logic             fd_q;
  logic             adv;
  logic             accept;
  logic             consume;

  assign adv     = enable & (recon_ready | ~vld[D-1]);
  assign accept  = adv & in_valid;
  assign consume = vld[D-1] & recon_ready & enable;

  assign in_ready       = adv;
  assign tc_enable      = vld[PRED_LAT-1];
  assign recon_valid    = vld[D-1];
  assign recon_mbnumber = mbn[D-1];
  assign recon_mode     = mde[D-1];
  assign pipeline_full  = (occ == OCC_FULL);
  // Pulse is held while frozen and shown on the first enabled cycle.
  assign frame_done     = fd_q & enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        mbn[i] <= '0;
        mde[i] <= '0;
      end
    end else if (adv) begin
      vld <= {vld[D-2:0], in_valid};
      mbn[0] <= in_mbnumber;
      mde[0] <= in_mode;
      for (int unsigned i = 1; i < D; i++) begin
        mbn[i] <= mbn[i-1];
        mde[i] <= mde[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ <= '0;
    end else if (accept && !consume) begin
      occ <= occ + 1'b1;
    end else if (consume && !accept) begin
      occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mb_cnt <= '0;
      fd_q   <= 1'b0;
    end else if (enable) begin
      fd_q <= consume && (mb_cnt == MB_LAST);
      if (consume) begin
        mb_cnt <= (mb_cnt == MB_LAST) ? '0 : mb_cnt + 1'b1;
      end
    end
  end

`ifdef INTRALOOP_ORDER_CHECK_EN
  localparam logic [MB_W-1:0] MBN_LAST = MB_W'(MBS_PER_FRAME - 1);

  logic            have_prev;
  logic [MB_W-1:0] prev_mb;
  logic [MB_W-1:0] next_mb;
  logic            err_q;

  // Out-of-range predecessors also wrap to 0.
  assign next_mb = (prev_mb >= MBN_LAST) ? '0 : prev_mb + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      have_prev <= 1'b0;
      prev_mb   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      have_prev <= 1'b1;
      prev_mb   <= in_mbnumber;
      if (have_prev && (in_mbnumber != next_mb)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign order_err = err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_intraloop_tagpipe.sv
// Self-checking bench for intraloop_tagpipe: directed table, hand sequences, randomized traffic vs queue model.
module tb_intraloop_tagpipe;
  localparam int NUM_CH = 3;
  localparam int MODE_W = 3;
  localparam int MW     = NUM_CH * MODE_W;
  localparam int MB_W   = 32;
  localparam int PRED   = 3;
  localparam int TC     = 8;
  localparam int D      = PRED + TC;
  localparam int MBS    = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [MB_W-1:0] in_mbnumber = '0;
  logic [MW-1:0]   in_mode = '0;
  logic            tc_enable;
  logic            recon_valid;
  logic            recon_ready = 1'b0;
  logic [MB_W-1:0] recon_mbnumber;
  logic [MW-1:0]   recon_mode;
  logic            pipeline_full;
  logic            frame_done;
  logic            order_err;

  intraloop_tagpipe #(
    .NUM_CH(NUM_CH), .MB_W(MB_W), .MODE_W(MODE_W),
    .PRED_LAT(PRED), .TC_LAT(TC), .MBS_PER_FRAME(MBS)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mbnumber(in_mbnumber), .in_mode(in_mode),
    .tc_enable(tc_enable), .recon_valid(recon_valid), .recon_ready(recon_ready),
    .recon_mbnumber(recon_mbnumber), .recon_mode(recon_mode),
    .pipeline_full(pipeline_full), .frame_done(frame_done), .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            v;
    logic [MB_W-1:0] mb;
    logic [MW-1:0]   md;
  } tag_t;

  typedef struct {
    logic            iv;
    logic [MB_W-1:0] mb;
    logic [MW-1:0]   md;
    logic            en;
    logic            rr;
    logic            e_rdy;
    logic            e_tc;
    logic            e_rv;
    logic [MB_W-1:0] e_mb;
    logic [MW-1:0]   e_md;
    logic            e_full;
    logic            e_fd;
  } vec_t;

  // Reference model: FIFO of D slots, oldest (reconstructor side) at index 0.
  tag_t            q[$];
  int              m_cnt;
  logic            m_fd;
  logic            m_err;
  logic            m_have;
  logic [MB_W-1:0] m_prev;

  int              n_vec = 0;
  int              n_err = 0;
  int              cyc = 0;
  logic [MB_W-1:0] got_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    repeat (D) q.push_back('0);
    m_cnt = 0; m_fd = 1'b0; m_err = 1'b0; m_have = 1'b0; m_prev = '0;
  endtask

  task automatic model_step();
    logic adv, cons;
    logic [MB_W-1:0] nxt;
    tag_t t;
    adv  = enable && (recon_ready || !q[0].v);
    cons = q[0].v && recon_ready && enable;
    if (enable) begin
      m_fd = 1'b0;
      if (cons) begin
        m_cnt = (m_cnt + 1) % MBS;
        m_fd  = (m_cnt == 0);
      end
    end
    if (adv && in_valid) begin
      nxt = (m_prev >= MB_W'(MBS - 1)) ? '0 : m_prev + 1;
`ifdef INTRALOOP_ORDER_CHECK_EN
      if (m_have && in_mbnumber != nxt) m_err = 1'b1;
`endif
      m_have = 1'b1;
      m_prev = in_mbnumber;
    end
    if (adv) begin
      t.v = in_valid; t.mb = in_mbnumber; t.md = in_mode;
      void'(q.pop_front());
      q.push_back(t);
    end
  endtask

  task automatic check_model();
    int nv;
    nv = 0;
    foreach (q[i]) if (q[i].v) nv++;
    chk("in_ready", in_ready, enable && (recon_ready || !q[0].v));
    chk("tc_enable", tc_enable, q[D-PRED].v);
    chk("recon_valid", recon_valid, q[0].v);
    chk("recon_mbnumber", recon_mbnumber, q[0].mb);
    chk("recon_mode", recon_mode, q[0].md);
    chk("pipeline_full", pipeline_full, nv == D);
    chk("frame_done", frame_done, m_fd && enable);
    chk("order_err", order_err, m_err);
    if (recon_valid && recon_ready && enable) got_q.push_back(recon_mbnumber);
  endtask

  task automatic drive(input logic iv, input logic [MB_W-1:0] mb, input logic [MW-1:0] md,
                       input logic en, input logic rr);
    @(negedge clk);
    in_valid = iv; in_mbnumber = mb; in_mode = md; enable = en; recon_ready = rr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  task automatic cycle(input logic iv, input logic [MB_W-1:0] mb, input logic [MW-1:0] md,
                       input logic en, input logic rr);
    drive(iv, mb, md, en, rr);
    check_model();
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_mbnumber = '0; in_mode = '0;
    enable = 1'b1; recon_ready = 1'b1;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    reset = 1'b1;
    tick();
    cyc = 0;
  endtask

  vec_t tbl[14];
  int   nm;
  int   fd_cnt;
  int   fd_cyc;

  initial begin
    model_reset();

    // Single tag latency and mode packing.
    for (int i = 0; i < 14; i++) begin
      tbl[i] = '{iv: 1'b0, mb: '0, md: '0, en: 1'b1, rr: 1'b1, e_rdy: 1'b1, e_tc: 1'b0,
                 e_rv: 1'b0, e_mb: '0, e_md: '0, e_full: 1'b0, e_fd: 1'b0};
    end
    tbl[0].iv = 1'b1; tbl[0].mb = 5; tbl[0].md = 9'h0D1;
    tbl[3].e_tc = 1'b1;
    tbl[11].e_rv = 1'b1; tbl[11].e_mb = 5; tbl[11].e_md = 9'h0D1;

    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].mb, tbl[i].md, tbl[i].en, tbl[i].rr);
      chk("tbl_in_ready", in_ready, tbl[i].e_rdy);
      chk("tbl_tc_enable", tc_enable, tbl[i].e_tc);
      chk("tbl_recon_valid", recon_valid, tbl[i].e_rv);
      chk("tbl_recon_mb", recon_mbnumber, tbl[i].e_mb);
      chk("tbl_recon_mode", recon_mode, tbl[i].e_md);
      chk("tbl_full", pipeline_full, tbl[i].e_full);
      chk("tbl_frame_done", frame_done, tbl[i].e_fd);
      check_model();
      tick();
    end

    // Continuous stream, fill, 4-cycle back-pressure, drain.
    do_reset();
    nm = 0;
    got_q.delete();
    for (int c = 0; c < 45; c++) begin
      drive(c < 22, nm, MW'(nm * 7), 1'b1, !(c >= 14 && c < 18));
      check_model();
      if (c == 10) chk("full_c10", pipeline_full, 0);
      if (c == 11) chk("full_c11", pipeline_full, 1);
      if (c >= 14 && c < 18) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_recon_mb", recon_mbnumber, 3);
        chk("stall_recon_valid", recon_valid, 1);
      end
      if (in_valid && in_ready) nm++;
      tick();
    end
    chk("stream_count", got_q.size(), nm);
    foreach (got_q[i]) chk("stream_order", got_q[i], i);

    // Frame wrap: 4 consumes, single frame_done one cycle after the last.
    do_reset();
    fd_cnt = 0; fd_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      drive(c < 4, c, '0, 1'b1, 1'b1);
      check_model();
      if (frame_done) begin fd_cnt++; fd_cyc = c; end
      tick();
    end
    chk("fd_pulses", fd_cnt, 1);
    chk("fd_cycle", fd_cyc, 15);

    // Reset with 6 tags in flight, first one at the output.
    do_reset();
    for (int c = 0; c < 11; c++) cycle(c < 6, 40 + c, MW'(c), 1'b1, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("pre_reset_recon_valid", recon_valid, 1);
    chk("pre_reset_recon_mb", recon_mbnumber, 40);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_recon_valid", recon_valid, 0);
    chk("rst_full", pipeline_full, 0);
    chk("rst_tc_enable", tc_enable, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    in_mbnumber = '0; in_mode = '0; recon_ready = 1'b1;
    tick();
    cyc = 0;
    fd_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      check_model();
      if (recon_valid || frame_done) fd_cnt++;
      tick();
    end
    chk("no_stale_after_reset", fd_cnt, 0);

`ifdef INTRALOOP_ORDER_CHECK_EN
    do_reset();
    cycle(1'b1, 0, '0, 1'b1, 1'b1);
    cycle(1'b1, 1, '0, 1'b1, 1'b1);
    drive(1'b1, 3, '0, 1'b1, 1'b1);
    chk("oe_before_bad", order_err, 0);
    check_model();
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      chk("oe_sticky", order_err, 1);
      check_model();
      tick();
    end
    do_reset();
    chk("oe_reset", order_err, 0);
`endif

    // Randomized traffic with enable and back-pressure gaps.
    do_reset();
    nm = 0;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 6, MB_W'(($urandom_range(0, 15) == 0) ? $urandom_range(0, MBS - 1) : nm),
            MW'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
      check_model();
      if (in_valid && in_ready) nm = (nm + 1) % MBS;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
